// File: rtl/led_cmd_serializer.sv
// Serializes one LED command (addr + state) into an 8-bit SCLK/SDATA frame plus a SLATCH strobe.
// Optional LED_CMD_ADDR_CHECK_EN: drop commands whose address is >= NUM_LEDS and pulse cmd_err.
module led_cmd_serializer #(
    parameter int CLK_DIV      = 4,
    parameter int LATCH_CYCLES = 4,
    parameter int NUM_LEDS     = 21
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [4:0] cmd_addr,
    input  logic [1:0] cmd_state,
    output logic       SCLK,
    output logic       SDATA,
    output logic       SLATCH,
    output logic       frame_done,
    output logic       cmd_err,
    output logic [2:0] dbg_state
);
    // Handshake: a command is taken on the rising edge where cmd_valid and cmd_ready are
    // both high; cmd_ready is registered, high only in IDLE, and inputs are not used after that edge.

    localparam int MAX_CNT = (CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATCH_CYCLES - 1);

    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_div
        $error("CLK_DIV out of range 1..255");
    end
    if (LATCH_CYCLES < 1 || LATCH_CYCLES > 255) begin : g_bad_latch
        $error("LATCH_CYCLES out of range 1..255");
    end
    if (NUM_LEDS < 1 || NUM_LEDS > 32) begin : g_bad_leds
        $error("NUM_LEDS out of range 1..32");
    end

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SHIFT_LO = 3'd1,
        S_SHIFT_HI = 3'd2,
        S_LATCH    = 3'd3,
        S_GAP      = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_word;
    logic             r_ready;
    logic             r_sclk;
    logic             r_sdata;
    logic             r_slatch;
    logic             r_frame_done;
    logic             r_cmd_err;

    logic [7:0]       w_word;
    logic             w_addr_bad;

    assign w_word = {1'b0, cmd_state, cmd_addr};

`ifdef LED_CMD_ADDR_CHECK_EN
    assign w_addr_bad = (int'(cmd_addr) >= NUM_LEDS);
`else
    assign w_addr_bad = 1'b0;
`endif

    // One down-counter times every phase; it is reloaded on each state entry.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= 3'd7;
            r_word       <= 8'h00;
            r_ready      <= 1'b0;
            r_sclk       <= 1'b0;
            r_sdata      <= 1'b0;
            r_slatch     <= 1'b0;
            r_frame_done <= 1'b0;
            r_cmd_err    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_cmd_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready  <= 1'b1;
                    r_sclk   <= 1'b0;
                    r_sdata  <= 1'b0;
                    r_slatch <= 1'b0;
                    if (cmd_valid && r_ready) begin
                        if (w_addr_bad) begin
                            r_cmd_err <= 1'b1;
                        end else begin
                            r_word  <= w_word;
                            r_idx   <= 3'd7;
                            r_cnt   <= DIV_LOAD;
                            r_sdata <= w_word[7];
                            r_ready <= 1'b0;
                            r_state <= S_SHIFT_LO;
                        end
                    end
                end
                S_SHIFT_LO: begin
                    if (r_cnt == '0) begin
                        r_sclk  <= 1'b1;
                        r_cnt   <= DIV_LOAD;
                        r_state <= S_SHIFT_HI;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_SHIFT_HI: begin
                    if (r_cnt == '0) begin
                        r_sclk <= 1'b0;
                        if (r_idx == 3'd0) begin
                            r_sdata  <= 1'b0;
                            r_slatch <= 1'b1;
                            r_cnt    <= LAT_LOAD;
                            r_state  <= S_LATCH;
                        end else begin
                            // Next bit is presented together with SCLK falling.
                            r_sdata <= r_word[r_idx - 3'd1];
                            r_idx   <= r_idx - 3'd1;
                            r_cnt   <= DIV_LOAD;
                            r_state <= S_SHIFT_LO;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_LATCH: begin
                    if (r_cnt == '0) begin
                        r_slatch     <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_cnt        <= DIV_LOAD;
                        r_state      <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_ready  <= 1'b0;
                    r_sclk   <= 1'b0;
                    r_sdata  <= 1'b0;
                    r_slatch <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = r_ready;
    assign SCLK       = r_sclk;
    assign SDATA      = r_sdata;
    assign SLATCH     = r_slatch;
    assign frame_done = r_frame_done;
    assign cmd_err    = r_cmd_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_led_cmd_serializer.sv
// Directed bench for led_cmd_serializer: default-timing instance (a) and CLK_DIV=1/LATCH_CYCLES=1 instance (b).
module tb_led_cmd_serializer;
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_valid, a_ready, a_sclk, a_sdata, a_slatch, a_fd, a_err;
  logic [4:0] a_addr;
  logic [1:0] a_state;
  logic [2:0] a_dbg;
  logic       b_valid, b_ready, b_sclk, b_sdata, b_slatch, b_fd, b_err;
  logic [4:0] b_addr;
  logic [1:0] b_state;
  logic [2:0] b_dbg;

  led_cmd_serializer u_a (
    .CLK(clk), .RESET(rst_n), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_addr(a_addr), .cmd_state(a_state), .SCLK(a_sclk), .SDATA(a_sdata),
    .SLATCH(a_slatch), .frame_done(a_fd), .cmd_err(a_err), .dbg_state(a_dbg)
  );

  led_cmd_serializer #(.CLK_DIV(1), .LATCH_CYCLES(1)) u_b (
    .CLK(clk), .RESET(rst_n), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_addr(b_addr), .cmd_state(b_state), .SCLK(b_sclk), .SDATA(b_sdata),
    .SLATCH(b_slatch), .frame_done(b_fd), .cmd_err(b_err), .dbg_state(b_dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // Per-instance observation, index 0 = u_a, 1 = u_b
  logic [1:0] m_sclk, m_sdata, m_slatch, m_fd, m_err, m_ready;
  assign m_sclk   = {b_sclk, a_sclk};
  assign m_sdata  = {b_sdata, a_sdata};
  assign m_slatch = {b_slatch, a_slatch};
  assign m_fd     = {b_fd, a_fd};
  assign m_err    = {b_err, a_err};
  assign m_ready  = {b_ready, a_ready};

  logic [7:0] bits[2];
  int nbits[2], rises[2], latch_cyc[2], fd_cnt[2], err_cnt[2], busy[2], viol[2], bad_latch[2];
  logic sclk_q[2], sdata_q[2], slatch_q[2];
  logic [7:0] a_frames[$];
  logic [7:0] b_frames[$];

  // Monitor samples 2 time units after each rising edge
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        nbits[i] = 0;
        bits[i] = 8'h00;
      end else if (m_sclk[i] && !sclk_q[i]) begin
        bits[i] = {bits[i][6:0], m_sdata[i]};
        nbits[i]++;
        rises[i]++;
      end
      if (m_sclk[i] && (m_sdata[i] !== sdata_q[i])) viol[i]++;
      if (m_slatch[i] && !slatch_q[i]) begin
        if (nbits[i] != 8) bad_latch[i]++;
        if (i == 0) a_frames.push_back(bits[i]);
        else b_frames.push_back(bits[i]);
        nbits[i] = 0;
      end
      if (m_slatch[i]) latch_cyc[i]++;
      if (m_fd[i]) fd_cnt[i]++;
      if (m_err[i]) err_cnt[i]++;
      if (!m_ready[i]) busy[i]++;
      sclk_q[i] = m_sclk[i];
      sdata_q[i] = m_sdata[i];
      slatch_q[i] = m_slatch[i];
    end
  end

  task automatic clr(input int sel);
    rises[sel] = 0; latch_cyc[sel] = 0; fd_cnt[sel] = 0; err_cnt[sel] = 0;
    busy[sel] = 0; viol[sel] = 0; bad_latch[sel] = 0;
    if (sel == 0) a_frames.delete();
    else b_frames.delete();
    exp_q.delete();
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with valid still high
  task automatic send(input int sel, input logic [4:0] ad, input logic [1:0] st);
    int n;
    n = 0;
    if (sel == 0) begin a_addr = ad; a_state = st; a_valid = 1'b1; end
    else begin b_addr = ad; b_state = st; b_valid = 1'b1; end
    while (!m_ready[sel] && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL send_ready_timeout inst=%0d waited=%0d limit=300", sel, n);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input int sel);
    int n;
    n = 0;
    while (!m_ready[sel] && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL idle_timeout inst=%0d waited=%0d limit=300", sel, n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frames_a();
    checks++;
    if (a_frames.size() != exp_q.size()) begin
      errors++;
      $display("FAIL frame_count got %0d expected %0d", a_frames.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && a_frames.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = a_frames.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL frame_data got %02h expected %02h", g, e);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_addr = 5'd0; a_state = 2'd0; b_addr = 5'd0; b_state = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_ready, a_sclk, a_sdata, a_slatch, a_fd, a_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs_a got %06b expected 000000", {a_ready, a_sclk, a_sdata, a_slatch, a_fd, a_err});
    end
    checks++;
    if (a_dbg !== 3'd0) begin errors++; $display("FAIL reset_state_a got %0d expected 0", a_dbg); end
    checks++;
    if ({b_ready, b_sclk, b_sdata, b_slatch, b_fd, b_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs_b got %06b expected 000000", {b_ready, b_sclk, b_sdata, b_slatch, b_fd, b_err});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b expected 1", a_ready); end
    checks++;
    if (b_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset_b got %b expected 1", b_ready); end
  endtask

  task automatic test_single_frame();
    clr(0);
    send(0, 5'd5, 2'd2);
    a_valid = 1'b0;
    exp_q.push_back(8'h45);
    checks++;
    if ({a_ready, a_sclk, a_sdata} !== 3'b000) begin
      errors++;
      $display("FAIL first_bit got ready/sclk/sdata=%03b expected 000", {a_ready, a_sclk, a_sdata});
    end
    wait_idle(0);
    check_frames_a();
    checks++;
    if (latch_cyc[0] != 4) begin errors++; $display("FAIL latch_width got %0d expected 4", latch_cyc[0]); end
    checks++;
    if (fd_cnt[0] != 1) begin errors++; $display("FAIL frame_done_count got %0d expected 1", fd_cnt[0]); end
    checks++;
    if (busy[0] != 72) begin errors++; $display("FAIL busy_window got %0d expected 72", busy[0]); end
    checks++;
    if (rises[0] != 8) begin errors++; $display("FAIL sclk_rises got %0d expected 8", rises[0]); end
    checks++;
    if (viol[0] != 0) begin errors++; $display("FAIL sdata_stable got %0d changes expected 0", viol[0]); end
    checks++;
    if (bad_latch[0] != 0) begin errors++; $display("FAIL latch_after_8_bits got %0d bad expected 0", bad_latch[0]); end
  endtask

  task automatic test_back_to_back();
    clr(0);
    send(0, 5'd0, 2'd1);
    exp_q.push_back(8'h20);
    send(0, 5'd20, 2'd3);
    exp_q.push_back(8'h74);
    a_valid = 1'b0;
    wait_idle(0);
    check_frames_a();
    checks++;
    if (fd_cnt[0] != 2) begin errors++; $display("FAIL b2b_frame_done got %0d expected 2", fd_cnt[0]); end
    checks++;
    if (busy[0] != 144) begin errors++; $display("FAIL b2b_busy got %0d expected 144", busy[0]); end
    checks++;
    if (bad_latch[0] != 0 || rises[0] != 16) begin
      errors++;
      $display("FAIL b2b_bits got rises=%0d bad=%0d expected rises=16 bad=0", rises[0], bad_latch[0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    clr(0);
    send(0, 5'd5, 2'd2);
    a_valid = 1'b0;
    n = 0;
    while (nbits[0] != 4 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin errors++; $display("FAIL mid_frame_timeout waited=%0d limit=300", n); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_ready, a_sclk, a_sdata, a_slatch, a_fd} !== 5'b0) begin
      errors++;
      $display("FAIL abort_outputs got %05b expected 00000", {a_ready, a_sclk, a_sdata, a_slatch, a_fd});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (latch_cyc[0] != 0 || a_frames.size() != 0) begin
      errors++;
      $display("FAIL abort_no_latch got latch_cycles=%0d frames=%0d expected 0 0", latch_cyc[0], a_frames.size());
    end
    clr(0);
    send(0, 5'd3, 2'd1);
    a_valid = 1'b0;
    exp_q.push_back(8'h23);
    wait_idle(0);
    check_frames_a();
    checks++;
    if (busy[0] != 72) begin errors++; $display("FAIL post_reset_busy got %0d expected 72", busy[0]); end
  endtask

  task automatic test_fast_timing();
    clr(1);
    send(1, 5'd5, 2'd2);
    b_valid = 1'b0;
    wait_idle(1);
    checks++;
    if (b_frames.size() != 1) begin
      errors++;
      $display("FAIL fast_frame_count got %0d expected 1", b_frames.size());
    end else begin
      checks++;
      if (b_frames[0] !== 8'h45) begin errors++; $display("FAIL fast_frame_data got %02h expected 45", b_frames[0]); end
    end
    checks++;
    if (busy[1] != 18) begin errors++; $display("FAIL fast_busy got %0d expected 18", busy[1]); end
    checks++;
    if (latch_cyc[1] != 1) begin errors++; $display("FAIL fast_latch_width got %0d expected 1", latch_cyc[1]); end
    checks++;
    if (rises[1] != 8 || viol[1] != 0 || fd_cnt[1] != 1) begin
      errors++;
      $display("FAIL fast_misc got rises=%0d viol=%0d fd=%0d expected 8 0 1", rises[1], viol[1], fd_cnt[1]);
    end
  endtask

  task automatic test_addr_check();
    clr(0);
    send(0, 5'd21, 2'd0);
    a_valid = 1'b0;
`ifdef LED_CMD_ADDR_CHECK_EN
    repeat (10) @(negedge clk);
    checks++;
    if (err_cnt[0] != 1) begin errors++; $display("FAIL addr_err_pulse got %0d expected 1", err_cnt[0]); end
    checks++;
    if (busy[0] != 0 || rises[0] != 0 || latch_cyc[0] != 0) begin
      errors++;
      $display("FAIL addr_dropped got busy=%0d rises=%0d latch=%0d expected 0 0 0", busy[0], rises[0], latch_cyc[0]);
    end
`else
    exp_q.push_back(8'h15);
    wait_idle(0);
    check_frames_a();
    checks++;
    if (err_cnt[0] != 0) begin errors++; $display("FAIL addr_no_err got %0d expected 0", err_cnt[0]); end
`endif
  endtask

  task automatic test_valid_while_busy();
    clr(0);
    send(0, 5'd9, 2'd1);
    a_valid = 1'b0;
    exp_q.push_back(8'h29);
    repeat (10) @(negedge clk);
    a_addr = 5'd1; a_state = 2'd3; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    wait_idle(0);
    repeat (5) @(negedge clk);
    check_frames_a();
    checks++;
    if (fd_cnt[0] != 1 || busy[0] != 72) begin
      errors++;
      $display("FAIL busy_ignore got fd=%0d busy=%0d expected 1 72", fd_cnt[0], busy[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      nbits[i] = 0; bits[i] = 8'h00; sclk_q[i] = 1'b0; sdata_q[i] = 1'b0; slatch_q[i] = 1'b0;
    end
    clr(0);
    clr(1);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_fast_timing();
    test_addr_check();
    test_valid_while_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
